// File: rtl/boot_load_arbiter_pkg.sv
// Shared types and widths for the boot-time loader arbiter.
package boot_load_pkg;

  localparam int BOOT_ADDR_W = 32;
  localparam int BE_W        = 4;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } boot_state_e;

  typedef enum logic {
    SPI = 1'b0,
    DBG = 1'b1
  } req_id_e;

endpackage

// File: rtl/boot_load_arbiter_if.sv
// One req/gnt/rvalid memory port, used for both loaders and the shared memory.
interface boot_mem_if;
  import boot_load_pkg::*;

  // Handshake: the master raises req with addr/we/be/wdata and holds them stable
  // until it sees gnt high in the same cycle (that cycle is the transfer). Every
  // accepted request, read or write, returns exactly one rvalid later, in issue order.
  logic                   req;
  logic                   gnt;
  logic [BOOT_ADDR_W-1:0] addr;
  logic                   we;
  logic [BE_W-1:0]        be;
  logic [DATA_W-1:0]      wdata;
  logic                   rvalid;
  logic [DATA_W-1:0]      rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/boot_load_arbiter_id_fifo.sv
// Small FIFO of requester IDs, one entry per accepted-but-unanswered transaction.
module boot_id_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_id,
  output logic          o_head,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty FIFO is dropped; a push while full only lands if a pop frees a slot.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (~w_push & w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_id;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/boot_load_arbiter.sv
// Boot controller: round-robin SPI/debug loaders onto the shared memory port,
// route responses back, hold the boot address and release fetch_enable once drained.
module boot_load_arbiter
  import boot_load_pkg::*;
#(
  parameter int                     RESET_WAIT    = 16,
  parameter int                     MAX_OUTST     = 2,
  parameter logic [BOOT_ADDR_W-1:0] BOOT_ADDR_RST = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_enable_i,
  input  logic                   boot_addr_we_i,
  input  logic [BOOT_ADDR_W-1:0] boot_addr_i,
  boot_mem_if.slave              spi_if,
  boot_mem_if.slave              dbg_if,
  boot_mem_if.master             mem_if,
  output logic                   fetch_enable_o,
  output logic [BOOT_ADDR_W-1:0] boot_addr_o,
  output logic [1:0]             state_o,
  output logic                   busy_o
);

  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam int         WCW      = $clog2(RESET_WAIT + 1);
  localparam int         CW       = $clog2(MAX_OUTST + 1);

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [WCW-1:0]         r_wait_cnt;
  logic                   r_fetch_en;
  logic [BOOT_ADDR_W-1:0] r_boot_addr;
  req_id_e                r_rr;
  req_id_e                r_sel;
  req_id_e                w_sel;
  logic                   r_pending;
  logic                   w_arb_on;
  logic                   w_elig;
  logic                   w_req;
  logic                   w_grant;
  logic                   w_pop;
  logic                   w_drained;
  logic                   w_fifo_head;
  logic                   w_fifo_empty;
  logic                   w_fifo_full;
  logic [CW-1:0]          w_outst;

  // A full window still accepts a request in the cycle a response frees a slot.
  assign w_arb_on = (r_state == ST_LOAD) | (r_state == ST_RUN);
  assign w_elig   = w_arb_on & (~w_fifo_full | mem_if.rvalid);
  assign w_req    = w_elig & (r_pending | spi_if.req | dbg_if.req);
  assign w_grant  = w_req & mem_if.gnt;
  assign w_pop    = mem_if.rvalid & ~w_fifo_empty;

  // r_pending pins the selection while a presented request waits for gnt.
  always_comb begin
    w_sel = SPI;
    if (r_pending)                    w_sel = r_sel;
    else if (spi_if.req & dbg_if.req) w_sel = r_rr;
    else if (dbg_if.req)              w_sel = DBG;
  end

  assign mem_if.req   = w_req;
  assign mem_if.addr  = (w_sel == DBG) ? dbg_if.addr  : spi_if.addr;
  assign mem_if.we    = (w_sel == DBG) ? dbg_if.we    : spi_if.we;
  assign mem_if.be    = (w_sel == DBG) ? dbg_if.be    : spi_if.be;
  assign mem_if.wdata = (w_sel == DBG) ? dbg_if.wdata : spi_if.wdata;

  assign spi_if.gnt    = w_grant & (w_sel == SPI);
  assign dbg_if.gnt    = w_grant & (w_sel == DBG);
  assign spi_if.rvalid = w_pop & (w_fifo_head == SPI);
  assign dbg_if.rvalid = w_pop & (w_fifo_head == DBG);
  assign spi_if.rdata  = mem_if.rdata;
  assign dbg_if.rdata  = mem_if.rdata;

  boot_id_fifo #(
    .DEPTH (MAX_OUTST),
    .CW    (CW)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_grant),
    .i_pop   (mem_if.rvalid),
    .i_id    (w_sel),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_outst)
  );

  // Drained means nothing is left after this cycle's response is consumed.
  assign w_drained = (w_outst == '0) | ((w_outst == CW'(1)) & w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT:  if (r_wait_cnt == WCW'(RESET_WAIT - 1)) w_state_next = ST_LOAD;
      ST_LOAD:  if (fetch_enable_i) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!fetch_enable_i) w_state_next = ST_LOAD;
        else if (w_drained)  w_state_next = ST_RUN;
      end
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT;
      r_wait_cnt  <= '0;
      r_fetch_en  <= 1'b0;
      r_boot_addr <= BOOT_ADDR_RST;
      r_rr        <= SPI;
      r_sel       <= SPI;
      r_pending   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_en <= (r_state == ST_RUN);
      r_pending  <= w_req & ~mem_if.gnt;
      if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (boot_addr_we_i && (r_state != ST_RUN)) r_boot_addr <= boot_addr_i;
      if (w_req) r_sel <= w_sel;
      if (w_grant) r_rr <= (w_sel == SPI) ? DBG : SPI;
    end
  end

  assign fetch_enable_o = r_fetch_en;
  assign boot_addr_o    = r_boot_addr;
  assign state_o        = r_state;
  assign busy_o         = ~w_fifo_empty;

endmodule
